pc_redirect_ctrl: RTL

//  Sequencing controller for the 10-bit program counter; all PC control goes through this block.

---
 rtl/pc_redirect_ctrl_if.sv | 38 +++
 rtl/pc_redirect_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Request/response bundle between the pipeline front end and the PC
// sequencing controller. The master side raises redirect requests and
// presents the current fetch address; the slave side drives the PC controls.
interface pc_redirect_ctrl_if #(
    parameter int unsigned AW = 10
);
    logic [AW-1:0] PcAddr;
    logic          Stall;
    logic          BrReq;
    logic [AW-1:0] BrTarget;
    logic          CallReq;
    logic [AW-1:0] CallTarget;
    logic [AW-1:0] CallRetAddr;
    logic          RetReq;
    logic          TrapReq;
    logic          HaltReq;
    logic          ResumeReq;

    logic          PcReset;
    logic          Jump;
    logic [AW-1:0] JumpTo;
    logic          Flush;
    logic          Halted;
    logic          RasOvf;
    logic          RasUnf;

    modport master (
        output PcAddr, Stall, BrReq, BrTarget, CallReq, CallTarget, CallRetAddr,
               RetReq, TrapReq, HaltReq, ResumeReq,
        input  PcReset, Jump, JumpTo, Flush, Halted, RasOvf, RasUnf
    );

    modport slave (
        input  PcAddr, Stall, BrReq, BrTarget, CallReq, CallTarget, CallRetAddr,
               RetReq, TrapReq, HaltReq, ResumeReq,
        output PcReset, Jump, JumpTo, Flush, Halted, RasOvf, RasUnf
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC sequencing controller: arbitrates trap/branch/call/return redirects,
// keeps a circular return-address stack, implements stall/halt by jumping
// the PC to its own address, and flushes younger stages after a redirect.
// Redirect latency is zero: PC controls are combinational from state+inputs.
module pc_redirect_ctrl #(
    parameter int unsigned    AW           = 10,
    parameter int unsigned    RAS_DEPTH    = 4,
    parameter logic [AW-1:0]  TRAP_VEC     = 10'h3F0,
    parameter int unsigned    FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               Reset,
    pc_redirect_ctrl_if.slave  bus
);

    localparam int unsigned   PW         = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned   CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [PW:0]   RAS_FULL   = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] fcnt, fcnt_nx;

    // ptr is the next free slot; the top entry sits at ptr-1, and when the
    // stack is full ptr also addresses the oldest entry, so a push there
    // overwrites it naturally.
    logic [AW-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   cnt;
    logic          ovf, unf;

    logic          do_push, do_pop, set_ovf, set_unf;
    logic          redirect, hold;
    logic [AW-1:0] redir_tgt;
    logic [AW-1:0] ras_top;
    logic          ras_empty;

    assign ras_top   = ras[ptr - 1'b1];
    assign ras_empty = (cnt == '0);

    // State register and flush counter
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= S_BOOT;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    // Return-stack pointer, occupancy and sticky error flags
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (do_push) begin
                ptr <= ptr + 1'b1;
                if (cnt != RAS_FULL) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (do_pop) begin
                ptr <= ptr - 1'b1;
                cnt <= cnt - 1'b1;
            end
            if (set_ovf) begin
                ovf <= 1'b1;
            end
            if (set_unf) begin
                unf <= 1'b1;
            end
        end
    end

    // Return-stack storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras[ptr] <= bus.CallRetAddr;
        end
    end

    // Next state: request arbitration, RAS actions and flush sequencing
    always_comb begin
        state_nx  = state;
        fcnt_nx   = fcnt;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        redirect  = 1'b0;
        hold      = 1'b0;
        redir_tgt = '0;
        case (state)
            S_BOOT: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (bus.TrapReq) begin
                    redirect  = 1'b1;
                    redir_tgt = TRAP_VEC;
                end else if (bus.BrReq) begin
                    redirect  = 1'b1;
                    redir_tgt = bus.BrTarget;
                end else if (bus.CallReq) begin
                    redirect  = 1'b1;
                    redir_tgt = bus.CallTarget;
                    do_push   = 1'b1;
                    set_ovf   = (cnt == RAS_FULL);
                end else if (bus.RetReq) begin
                    redirect = 1'b1;
                    if (!ras_empty) begin
                        redir_tgt = ras_top;
                        do_pop    = 1'b1;
                    end else begin
                        redir_tgt = TRAP_VEC;
                        set_unf   = 1'b1;
                    end
                end else if (bus.HaltReq) begin
                    hold     = 1'b1;
                    state_nx = S_HALT;
                end else if (bus.Stall) begin
                    hold = 1'b1;
                end
            end
            S_FLUSH: begin
                if (bus.TrapReq) begin
                    redirect  = 1'b1;
                    redir_tgt = TRAP_VEC;
                end else begin
                    hold = bus.Stall;
                    if (fcnt <= CW'(1)) begin
                        state_nx = S_RUN;
                    end else begin
                        fcnt_nx = fcnt - 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (bus.TrapReq) begin
                    redirect  = 1'b1;
                    redir_tgt = TRAP_VEC;
                end else if (bus.ResumeReq) begin
                    state_nx = S_RUN;
                end else begin
                    hold = 1'b1;
                end
            end
            default: begin
                state_nx = S_BOOT;
            end
        endcase
        if (redirect) begin
            fcnt_nx  = FLUSH_LOAD;
            state_nx = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
        end
    end

    // PC control outputs; Reset overrides everything combinationally
    always_comb begin
        bus.PcReset = 1'b0;
        bus.Jump    = 1'b0;
        bus.JumpTo  = '0;
        bus.Flush   = 1'b0;
        bus.Halted  = 1'b0;
        bus.RasOvf  = ovf;
        bus.RasUnf  = unf;
        if (Reset) begin
            bus.PcReset = 1'b1;
        end else if (state == S_BOOT) begin
            bus.PcReset = 1'b1;
            bus.Flush   = 1'b1;
        end else begin
            bus.Jump   = redirect | hold;
            bus.JumpTo = redirect ? redir_tgt : (hold ? bus.PcAddr : '0);
            bus.Flush  = redirect | (state == S_FLUSH);
            bus.Halted = (state == S_HALT);
        end
    end

endmodule
